// File: rtl/word_demux4_if.sv
// Handshake bundle for word_demux4: one producer-side input stream and four
// consumer-side output channels, plus the accepted-word counter.
interface word_demux4_if #(
  parameter int W = 16
);
  // producer side
  logic [0:1]   i_sel;
  logic [0:W-1] i_val;
  logic         i_valid;
  logic         o_ready;
  // consumer channels
  logic [0:W-1] o_val0, o_val1, o_val2, o_val3;
  logic         o_valid0, o_valid1, o_valid2, o_valid3;
  logic         i_ready0, i_ready1, i_ready2, i_ready3;
  // statistics
  logic [7:0]   o_count;

  // driver of the block (producer + consumers)
  modport master (
    output i_sel, i_val, i_valid,
    output i_ready0, i_ready1, i_ready2, i_ready3,
    input  o_ready,
    input  o_val0, o_val1, o_val2, o_val3,
    input  o_valid0, o_valid1, o_valid2, o_valid3,
    input  o_count
  );

  // the demux itself
  modport slave (
    input  i_sel, i_val, i_valid,
    input  i_ready0, i_ready1, i_ready2, i_ready3,
    output o_ready,
    output o_val0, o_val1, o_val2, o_val3,
    output o_valid0, o_valid1, o_valid2, o_valid3,
    output o_count
  );
endinterface

// File: rtl/word_demux4.sv
// word_demux4: routes one valid/ready word stream into four one-entry
// holding registers, selected by i_sel. Each channel drains independently.

// One-entry holding register for a single output channel.
module word_demux4_chan #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,   // input transfer targeting this channel
  input  logic [0:W-1] data,
  input  logic         ready,  // consumer takes the word this cycle
  output logic [0:W-1] val,
  output logic         valid
);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0] state, state_nxt;

  // next state: a load always wins (drain + reload keeps the channel full)
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (load) state_nxt = ST_FULL;
      ST_FULL: begin
        if (load)       state_nxt = ST_FULL;
        else if (ready) state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // state register, cleared asynchronously so held words are discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  // data register only moves on a load, so it holds across drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       val <= '0;
    else if (load) val <= data;
  end

  assign valid = (state == ST_FULL);
endmodule

module word_demux4 #(
  parameter int W = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  word_demux4_if.slave bus
);
  localparam int NUM_LANES = 4;

  logic [1:0]                     sel_idx;
  logic [NUM_LANES-1:0]           ready_c;
  logic [NUM_LANES-1:0]           valid_c;
  logic [NUM_LANES-1:0]           load;
  logic [NUM_LANES-1:0][0:W-1]    val_c;
  logic                           take;
  logic [7:0]                     count;

  // i_sel bit 0 is the MSB, so a left-aligned copy gives the channel number
  assign sel_idx = bus.i_sel;
  assign ready_c = {bus.i_ready3, bus.i_ready2, bus.i_ready1, bus.i_ready0};

  // accept when the selected slot is free now or is being drained this cycle;
  // deliberately independent of i_valid
  assign bus.o_ready = !i_rst && (!valid_c[sel_idx] || ready_c[sel_idx]);
  assign take        = bus.i_valid && bus.o_ready;

  generate
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_load
      assign load[k] = take && (sel_idx == 2'(k));
    end
  endgenerate

  word_demux4_chan #(.W(W)) u_chan [NUM_LANES-1:0] (
    .clk   (i_clk),
    .rst   (i_rst),
    .load  (load),
    .data  (bus.i_val),
    .ready (ready_c),
    .val   (val_c),
    .valid (valid_c)
  );

  // accepted-word counter, wraps naturally at 256
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     count <= '0;
    else if (take) count <= count + 8'd1;
  end

  assign bus.o_val0   = val_c[0];
  assign bus.o_val1   = val_c[1];
  assign bus.o_val2   = val_c[2];
  assign bus.o_val3   = val_c[3];
  assign bus.o_valid0 = valid_c[0];
  assign bus.o_valid1 = valid_c[1];
  assign bus.o_valid2 = valid_c[2];
  assign bus.o_valid3 = valid_c[3];
  assign bus.o_count  = count;
endmodule

// File: tb/tb_word_demux4.sv
// Scoreboard bench for word_demux4: the driver pushes accepted words into
// per-channel expectation queues, an independent negedge monitor pops and
// compares whenever a channel delivers.
module tb_word_demux4;
  localparam int W = 16;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  word_demux4_if #(.W(W)) bus ();
  word_demux4 #(.W(W)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // reference model: per-channel occupancy and FIFO of expected deliveries
  logic [W-1:0] exp_q [4][$];
  bit   occ  [4];
  bit   nocc [4];
  logic [7:0] mcount = 8'd0;
  bit   rel = 1'b0;
  bit   mon_on = 1'b0;

  logic [0:W-1] ov  [4];
  logic         ovd [4];
  logic         ir  [4];
  assign ov[0] = bus.o_val0;  assign ov[1] = bus.o_val1;
  assign ov[2] = bus.o_val2;  assign ov[3] = bus.o_val3;
  assign ovd[0] = bus.o_valid0; assign ovd[1] = bus.o_valid1;
  assign ovd[2] = bus.o_valid2; assign ovd[3] = bus.o_valid3;
  assign ir[0] = bus.i_ready0; assign ir[1] = bus.i_ready1;
  assign ir[2] = bus.i_ready2; assign ir[3] = bus.i_ready3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: valid must match model occupancy; a delivery pops the oldest word
  always @(negedge i_clk) begin
    if (mon_on && !i_rst) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("o_valid%0d", k), 64'(ovd[k]), 64'(occ[k]));
        if (ovd[k] && ir[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL deliver%0d: got %0h expected no word", k, ov[k]);
          end else begin
            chk($sformatf("deliver%0d", k), 64'(ov[k]), 64'(exp_q[k].pop_front()));
          end
        end
      end
    end
  end

  // one clock of stimulus; returns at posedge+4 so callers can inspect state
  task automatic step(input bit v, input logic [1:0] s, input logic [W-1:0] d,
                      input logic [3:0] rdy);
    bit exp_rdy, acc;
    @(posedge i_clk);
    for (int k = 0; k < 4; k++) occ[k] = nocc[k];
    #1;
    if (rel) begin i_rst = 1'b0; rel = 1'b0; end
    bus.i_valid = v; bus.i_sel = s; bus.i_val = d;
    bus.i_ready0 = rdy[0]; bus.i_ready1 = rdy[1];
    bus.i_ready2 = rdy[2]; bus.i_ready3 = rdy[3];
    #3;
    exp_rdy = !occ[s] || rdy[s];
    chk("o_ready", 64'(bus.o_ready), 64'(exp_rdy));
    chk("o_count", 64'(bus.o_count), 64'(mcount));
    acc = v && exp_rdy;
    for (int k = 0; k < 4; k++)
      nocc[k] = (acc && s == 2'(k)) ? 1'b1 : (occ[k] && rdy[k]) ? 1'b0 : occ[k];
    if (acc) begin
      exp_q[s].push_back(d);
      mcount = mcount + 8'd1;
    end
  endtask

  // reset asserted mid-cycle; outputs must clear without any clock edge
  task automatic reset_pulse();
    @(posedge i_clk);
    for (int k = 0; k < 4; k++) occ[k] = nocc[k];
    #2 i_rst = 1'b1;
    bus.i_valid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_valid%0d", k), 64'(ovd[k]), 64'd0);
      chk($sformatf("rst_val%0d", k), 64'(ov[k]), 64'd0);
      exp_q[k].delete();
      occ[k] = 1'b0; nocc[k] = 1'b0;
    end
    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_ready", 64'(bus.o_ready), 64'd0);
    mcount = 8'd0;
    rel = 1'b1;
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_sel = 2'd0; bus.i_val = '0;
    bus.i_ready0 = 1'b0; bus.i_ready1 = 1'b0;
    bus.i_ready2 = 1'b0; bus.i_ready3 = 1'b0;
    for (int k = 0; k < 4; k++) begin occ[k] = 1'b0; nocc[k] = 1'b0; end
    #12;
    for (int k = 0; k < 4; k++) chk($sformatf("init_valid%0d", k), 64'(ovd[k]), 64'd0);
    chk("init_count", 64'(bus.o_count), 64'd0);
    chk("init_ready", 64'(bus.o_ready), 64'd0);
    rel = 1'b1;
    mon_on = 1'b1;

    // routing
    step(1, 2'd2, 16'h1234, 4'h0);
    step(0, 2'd0, 16'h0000, 4'h0);
    chk("route_val2", 64'(ov[2]), 64'h1234);
    chk("route_count", 64'(bus.o_count), 64'd1);
    step(0, 2'd0, 16'h0000, 4'h4);

    // backpressure on channel 1, then a different channel accepts
    step(1, 2'd1, 16'hBEEF, 4'h0);
    step(1, 2'd1, 16'hCAFE, 4'h0);
    chk("bp_ready", 64'(bus.o_ready), 64'd0);
    step(1, 2'd3, 16'h7777, 4'h0);
    step(0, 2'd0, 16'h0000, 4'h0);
    chk("bp_val1", 64'(ov[1]), 64'hBEEF);
    chk("bp_val3", 64'(ov[3]), 64'h7777);
    step(0, 2'd0, 16'h0000, 4'hA);

    // simultaneous drain and load on channel 0
    step(1, 2'd0, 16'hAAAA, 4'h0);
    step(1, 2'd0, 16'h5555, 4'h1);
    chk("sdl_ready", 64'(bus.o_ready), 64'd1);
    step(0, 2'd0, 16'h0000, 4'h1);
    chk("sdl_val0", 64'(ov[0]), 64'h5555);
    step(0, 2'd0, 16'h0000, 4'h0);
    chk("retain_val0", 64'(ov[0]), 64'h5555);

    // fill all channels then reset mid-operation; first edge after release accepts
    for (int k = 0; k < 4; k++) step(1, 2'(k), 16'(16'h0100 + k), 4'h0);
    reset_pulse();
    step(1, 2'd1, 16'h0F0F, 4'h0);
    step(0, 2'd0, 16'h0000, 4'h2);
    chk("rel_val1", 64'(ov[1]), 64'h0F0F);

    // 300-word stream from a fresh reset, all consumers ready
    reset_pulse();
    for (int i = 0; i < 300; i++) step(1, 2'(i % 4), 16'($urandom), 4'hF);
    step(0, 2'd0, 16'h0000, 4'hF);
    chk("stream_count", 64'(bus.o_count), 64'd44);

    // random stress
    for (int i = 0; i < 2000; i++)
      step(($urandom % 4) != 0, 2'($urandom), 16'($urandom), 4'($urandom));
    for (int i = 0; i < 3; i++) step(0, 2'd0, 16'h0000, 4'hF);
    for (int k = 0; k < 4; k++)
      chk($sformatf("leftover%0d", k), 64'(exp_q[k].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
